// File: rtl/vote_pkg.sv
// Shared types and helpers for the majority-voter self-test sequencer.
package vote_pkg;

  localparam int NUM_VOTERS   = 5;
  localparam int NUM_PATTERNS = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    CHECK = 2'd2,
    FIN   = 2'd3
  } state_t;

  function automatic logic [2:0] popcount5(input logic [NUM_VOTERS-1:0] v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < NUM_VOTERS; i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return cnt;
  endfunction

endpackage

// File: rtl/vote_golden.sv
// Golden majority model: expected voter output for a given ballot.
module vote_golden
  import vote_pkg::*;
#(
  parameter int MAJ_K = 3
) (
  input  logic [NUM_VOTERS-1:0] votes,
  output logic                  expected
);

  assign expected = (int'(popcount5(votes)) >= MAJ_K);

endmodule

// File: rtl/vote_scan_ctrl.sv
// Exhaustive in-hardware self-test of a five-input majority voter.
// Optional macro VOTE_SCAN_HOLD_EN: stop the scan at the first mismatch.
module vote_scan_ctrl
  import vote_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int MAJ_K  = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [4:0] votes,
  input  logic       verdict,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [5:0] err_cnt,
  output logic [4:0] first_err
);

  // SETTLE is legal in 1..15, so the settle counter fits in 4 bits.
  localparam logic [3:0] SETTLE_LAST  = 4'(SETTLE - 1);
  localparam logic [4:0] LAST_PATTERN = 5'(NUM_PATTERNS - 1);

  state_t     r_state;
  state_t     w_next;
  logic [4:0] r_pattern;
  logic [3:0] r_settle;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [5:0] r_err_cnt;
  logic [4:0] r_first_err;
  logic       w_expected;
  logic       w_mismatch;
  logic       w_last;

  vote_golden #(.MAJ_K(MAJ_K)) u_golden (
    .votes    (r_pattern),
    .expected (w_expected)
  );

  assign w_mismatch = (verdict != w_expected);
  assign w_last     = (r_pattern == LAST_PATTERN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:  if (start) w_next = DRIVE;
      DRIVE: if (r_settle == SETTLE_LAST) w_next = CHECK;
      CHECK: begin
`ifdef VOTE_SCAN_HOLD_EN
        if (w_mismatch || w_last) w_next = FIN;
        else                      w_next = DRIVE;
`else
        if (w_last) w_next = FIN;
        else        w_next = DRIVE;
`endif
      end
      FIN:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // busy drops on entry to FIN; done and pass are registered on leaving FIN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pattern   <= 5'd0;
      r_settle    <= 4'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_err_cnt   <= 6'd0;
      r_first_err <= 5'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_pattern   <= 5'd0;
            r_settle    <= 4'd0;
            r_err_cnt   <= 6'd0;
            r_first_err <= 5'd0;
            r_pass      <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        DRIVE: begin
          if (r_settle == SETTLE_LAST) r_settle <= 4'd0;
          else                         r_settle <= r_settle + 4'd1;
        end
        CHECK: begin
          if (w_mismatch) begin
            r_err_cnt <= r_err_cnt + 6'd1;
            if (r_err_cnt == 6'd0) r_first_err <= r_pattern;
          end
          if (w_next == FIN) r_busy    <= 1'b0;
          else               r_pattern <= r_pattern + 5'd1;
        end
        FIN: begin
          r_done <= 1'b1;
          r_pass <= (r_err_cnt == 6'd0);
        end
        default: ;
      endcase
    end
  end

  assign votes     = r_pattern;
  assign busy      = r_busy;
  assign done      = r_done;
  assign pass      = r_pass;
  assign err_cnt   = r_err_cnt;
  assign first_err = r_first_err;

endmodule

// File: tb/tb_vote_scan_ctrl.sv
// Self-checking bench for vote_scan_ctrl: behavioural voter models and an
// independent scan-result model, with directed and randomized voter faults.
module tb_vote_scan_ctrl;

  localparam int SETTLE = 2;
  localparam int MAJ_K  = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  votes;
  logic        verdict;
  logic        busy;
  logic        done;
  logic        pass;
  logic [5:0]  err_cnt;
  logic [4:0]  first_err;

  int          voterMode = 0;
  logic [31:0] flipMask = 32'd0;
  int          checks = 0;
  int          errors = 0;

  vote_scan_ctrl #(.SETTLE(SETTLE), .MAJ_K(MAJ_K)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .votes     (votes),
    .verdict   (verdict),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_cnt   (err_cnt),
    .first_err (first_err)
  );

  always #5 clk = ~clk;

  function automatic int countBits(input logic [4:0] v);
    int n;
    n = 0;
    for (int i = 0; i < 5; i++) n += int'(v[i]);
    return n;
  endfunction

  function automatic logic refMajority(input logic [4:0] v);
    return countBits(v) >= MAJ_K;
  endfunction

  // Voter under test: 0 ideal, 1 stuck at 0, 2 ignores A5, else ideal with flipped patterns.
  function automatic logic voterOut(input logic [4:0] v, input int mode, input logic [31:0] mask);
    case (mode)
      0:       return refMajority(v);
      1:       return 1'b0;
      2:       return countBits({1'b0, v[3:0]}) >= 3;
      default: return refMajority(v) ^ mask[v];
    endcase
  endfunction

  always_comb verdict = voterOut(votes, voterMode, flipMask);

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit rePulse);
    int   nErr, firstP, lastP, doneAt, busyCnt;
    bit   pulsed;
    logic [4:0] p;
    nErr = 0; firstP = 0; pulsed = 0; doneAt = 0;
    for (int i = 0; i < 32; i++) begin
      p = 5'(i);
      if (voterOut(p, voterMode, flipMask) != refMajority(p)) begin
        if (nErr == 0) firstP = i;
        nErr++;
      end
    end
`ifdef VOTE_SCAN_HOLD_EN
    lastP = (nErr != 0) ? firstP : 31;
    if (nErr > 1) nErr = 1;
`else
    lastP = 31;
`endif
    @(negedge clk) start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    checkOutput("busyAfterStart", 32'(busy), 32'd1);
    checkOutput("votesAfterStart", 32'(votes), 32'd0);
    busyCnt = busy ? 1 : 0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk);
      #1;
      if (rePulse && !pulsed && votes == 5'd5) begin
        start = 1'b1;
        pulsed = 1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        doneAt = k;
        break;
      end
      if (busy) busyCnt++;
    end
    start = 1'b0;
    checkOutput("doneLatency", 32'(doneAt), 32'(lastP * (SETTLE + 1) + SETTLE + 2));
    checkOutput("busyCycles", 32'(busyCnt), 32'(lastP * (SETTLE + 1) + SETTLE + 1));
    checkOutput("errCnt", 32'(err_cnt), 32'(nErr));
    if (nErr != 0) checkOutput("firstErr", 32'(first_err), 32'(firstP));
    checkOutput("pass", 32'(pass), 32'(nErr == 0));
    checkOutput("votesHeld", 32'(votes), 32'(lastP));
    checkOutput("busyAtDone", 32'(busy), 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      checkOutput("doneOnePulse", 32'(done), 32'd0);
      checkOutput("noRestart", 32'(busy), 32'd0);
    end
    checkOutput("errCntStable", 32'(err_cnt), 32'(nErr));
  endtask

  task automatic midScanReset();
    bit reached;
    reached = 0;
    voterMode = 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #1;
      if (votes == 5'd10) begin
        reached = 1;
        break;
      end
    end
    checkOutput("reachedPattern10", 32'(reached), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstVotes", 32'(votes), 32'd0);
    checkOutput("rstErrCnt", 32'(err_cnt), 32'd0);
    checkOutput("rstFirstErr", 32'(first_err), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 checkOutput("rstNoDone", 32'(done), 32'd0);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 checkOutput("idleAfterRst", 32'(busy | done), 32'd0);
    end
    voterMode = 0;
    applyStimulus(0);
  endtask

  initial begin
    #3;
    checkOutput("resetVotes", 32'(votes), 32'd0);
    checkOutput("resetBusy", 32'(busy), 32'd0);
    checkOutput("resetDone", 32'(done), 32'd0);
    checkOutput("resetPass", 32'(pass), 32'd0);
    checkOutput("resetErrCnt", 32'(err_cnt), 32'd0);
    checkOutput("resetFirstErr", 32'(first_err), 32'd0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;

    $display("[TB] ideal voter");
    voterMode = 0; applyStimulus(0);
    $display("[TB] verdict stuck at 0");
    voterMode = 1; applyStimulus(0);
    $display("[TB] voter ignoring A5");
    voterMode = 2; applyStimulus(0);
    $display("[TB] start re-pulsed while busy");
    voterMode = 0; applyStimulus(1);
    $display("[TB] reset mid-scan");
    midScanReset();

    for (int r = 0; r < 8; r++) begin
      voterMode = 3;
      case (r % 4)
        0:       flipMask = $urandom();
        1:       flipMask = $urandom() & $urandom() & $urandom();
        2:       flipMask = 32'd1 << $urandom_range(31, 0);
        default: flipMask = (r == 3) ? 32'h8000_0000 : 32'd0;
      endcase
      $display("[TB] random fault mask %08h", flipMask);
      applyStimulus(0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vote_scan_ctrl.md
# vote_scan_ctrl

Self-test sequencer for the five-input majority voter. It drives all 32 ballot patterns onto the voter's A1..A5 inputs and waits a programmable settle time after each one. It then samples the voter's OUT, checks it against a built-in golden majority model and reports pass/fail, error count and first failing pattern. It sits on the driving side of the voter interface and replaces open-loop stimulus with an in-hardware exhaustive check.

## Interface
Parameters:
- SETTLE, default 2: cycles each pattern is held before OUT is sampled; legal range 1..15.
- MAJ_K, default 3: golden threshold; expected verdict is 1 when popcount(votes) >= MAJ_K.

Ports:
- clk, in, 1: single clock; all state updates on the rising edge.
- rst_n, in, 1: reset, asynchronous, active-low.
- start, in, 1: scan request; sampled only in IDLE.
- votes, out, 5: ballot to the voter; bit0=A1 … bit4=A5.
- verdict, in, 1: voter OUT; treated as settled by sample time, no synchronizer.
- busy, out, 1: high from the cycle after start is accepted until done.
- done, out, 1: one-cycle completion pulse.
- pass, out, 1: valid from done; 1 when err_cnt==0.
- err_cnt, out, 6: mismatch count, 0..32.
- first_err, out, 5: first mismatching pattern; valid when err_cnt!=0.

## Operation
- Reset values: all outputs are 0; FSM is in IDLE; pattern counter is 0.
- FSM states: IDLE, DRIVE, CHECK, FIN.
- IDLE:
  - start=1 moves to DRIVE.
  - On that transition: votes, err_cnt, first_err and pass are cleared; busy is set.
- DRIVE:
  - votes=pattern; the settle counter counts SETTLE cycles, then moves to CHECK.
- CHECK:
  - One cycle; sample verdict and compare to golden(pattern).
  - On mismatch: err_cnt+1. If this is the first mismatch, first_err=pattern.
  - If pattern==31, go to FIN. Otherwise pattern+1 and back to DRIVE.
  - The pattern counter is 5 bits; the pattern==31 check detects the end before any wrap.
- FIN:
  - One cycle. done=1, busy=0, pass=(err_cnt==0), then IDLE.
- votes holds the last pattern (31) after the scan, until the next start or reset.
- start while busy is ignored; start held high re-arms only after FIN has returned to IDLE.
- err_cnt cannot overflow: 6 bits for at most 32 mismatches.

## Timing
- Start edge = T. busy=1 and votes=0 are visible after edge T.
- Each pattern takes SETTLE+1 cycles: SETTLE in DRIVE, 1 in CHECK.
- The verdict for pattern p is sampled at edge T + p·(SETTLE+1) + SETTLE + 1.
- done is high for the cycle following edge T + 32·(SETTLE+1) + 1. With SETTLE=2 that is 97 edges after T.
- pass, err_cnt and first_err are stable from done until the next accepted start.
- rst_n low at any time, mid-scan included:
  - All outputs go to reset values immediately; no done pulse.
  - Operation resumes in IDLE after deassertion.
- A mismatch in the same CHECK cycle as pattern 31 is counted before done is raised.

## Configuration
- VOTE_SCAN_HOLD_EN defined:
  - The first mismatch ends the scan. CHECK goes directly to FIN.
  - votes holds the failing pattern; err_cnt=1, pass=0, done pulses one cycle later.
- Undefined: all 32 patterns are always scanned and every mismatch is counted.

## Structure
- Package vote_pkg:
  - State enum (IDLE/DRIVE/CHECK/FIN).
  - NUM_VOTERS=5 and NUM_PATTERNS=32.
  - 5-bit popcount function.
- Sub-module vote_golden: combinational, input votes[4:0] and parameter MAJ_K, output expected.
  - Kept separate so the bench reuses it as its reference model.

## Test plan
- Ideal voter (OUT=popcount>=3), SETTLE=2, start at T → done pulse 97 edges after T; pass=1, err_cnt=0, busy high 96 cycles.
- Verdict stuck at 0 → err_cnt=16, first_err=5'b00111, pass=0.
- Voter ignoring A5 (OUT=popcount(A1..A4)>=3) → err_cnt=6, first_err=5'b10011.
- rst_n pulsed low while votes=10 → outputs immediately 0, no done; a following start gives a full 97-edge scan with correct result.
- start re-pulsed while busy at pattern 5 → no restart; done timing unchanged; one scan only.
- VOTE_SCAN_HOLD_EN with verdict stuck at 0 → done after checking pattern 7, votes held 5'b00111, err_cnt=1, pass=0.
